voice_mixer: RTL and testbench

- Time-multiplexed mixer between the voice generators and the pdm_dac.
- Takes NUM_VOICES offset-binary voice samples, applies a per-voice volume and a master volume, and saturates the result.
- Presents one offset-binary sample per sample_strobe to the DAC input.
- One shared multiplier and accumulator, stepped over the voices sequentially by an FSM.

---
 rtl/voice_mixer_if.sv | 29 ++
 rtl/voice_mixer.sv | 126 ++++++++++++
 tb/tb_voice_mixer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/voice_mixer_if.sv
// Voice mixer bus: strobe, packed voice/volume inputs and mixed DAC output.
// VOICE_MIXER_CLIP_COUNT_EN adds the clip_clear / clip_count pair.
interface voice_mixer_if #(
    parameter int NUM_VOICES = 4,
    parameter int DATA_BITS  = 12,
    parameter int VOL_BITS   = 4
);
    logic                            sample_strobe;
    logic [NUM_VOICES*DATA_BITS-1:0] voice_in;
    logic [NUM_VOICES*VOL_BITS-1:0]  voice_vol;
    logic [VOL_BITS-1:0]             master_vol;
    logic [DATA_BITS-1:0]            dout;
    logic                            dout_valid;
    logic                            busy;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
    logic                            clip_clear;
    logic [7:0]                      clip_count;

    modport master (output sample_strobe, voice_in, voice_vol, master_vol, clip_clear,
                    input  dout, dout_valid, busy, clip_count);
    modport slave  (input  sample_strobe, voice_in, voice_vol, master_vol, clip_clear,
                    output dout, dout_valid, busy, clip_count);
`else
    modport master (output sample_strobe, voice_in, voice_vol, master_vol,
                    input  dout, dout_valid, busy);
    modport slave  (input  sample_strobe, voice_in, voice_vol, master_vol,
                    output dout, dout_valid, busy);
`endif
endinterface

// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: one shared multiplier steps through the voices,
// applies master volume, saturates. Optional clip counter: VOICE_MIXER_CLIP_COUNT_EN.
module voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int DATA_BITS  = 12,
    parameter int VOL_BITS   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    voice_mixer_if.slave  bus
);
    localparam int PROD_W = DATA_BITS + VOL_BITS + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_VOICES);
    localparam int MP_W   = ACC_W + VOL_BITS + 1;
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic signed [MP_W-1:0] SMAX = MP_W'((1 << (DATA_BITS-1)) - 1);
    localparam logic signed [MP_W-1:0] SMIN = -SMAX - MP_W'(1);
    localparam logic [DATA_BITS-1:0]   MID  = DATA_BITS'(1 << (DATA_BITS-1));

    typedef enum logic [1:0] {IDLE, ACCUM, MASTER, OUT} state_t;

    state_t                           state_q, state_d;
    logic [NUM_VOICES*DATA_BITS-1:0]  voice_q, voice_d;
    logic [NUM_VOICES*VOL_BITS-1:0]   vol_q, vol_d;
    logic [VOL_BITS-1:0]              mvol_q, mvol_d;
    logic signed [ACC_W-1:0]          acc_q, acc_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [DATA_BITS-1:0]             dout_q, dout_d;

    logic [DATA_BITS-1:0]             cur_raw;
    logic signed [DATA_BITS-1:0]      cur_s;
    logic signed [VOL_BITS:0]         cur_v, mst_v;
    logic signed [PROD_W-1:0]         prod;
    logic signed [MP_W-1:0]           mprod, shifted;
    logic signed [DATA_BITS-1:0]      sat;

    // Offset binary to two's complement is an MSB flip; volumes are zero-extended.
    assign cur_raw = voice_q[idx_q*DATA_BITS +: DATA_BITS];
    assign cur_s   = {~cur_raw[DATA_BITS-1], cur_raw[DATA_BITS-2:0]};
    assign cur_v   = {1'b0, vol_q[idx_q*VOL_BITS +: VOL_BITS]};
    assign mst_v   = {1'b0, mvol_q};
    assign prod    = PROD_W'(cur_s) * PROD_W'(cur_v);
    assign mprod   = MP_W'(acc_q) * MP_W'(mst_v);
    assign shifted = mprod >>> (2*VOL_BITS);

    always_comb begin
        if (shifted > SMAX)      sat = SMAX[DATA_BITS-1:0];
        else if (shifted < SMIN) sat = SMIN[DATA_BITS-1:0];
        else                     sat = shifted[DATA_BITS-1:0];
    end

    always_comb begin
        state_d = state_q;
        voice_d = voice_q;
        vol_d   = vol_q;
        mvol_d  = mvol_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: if (bus.sample_strobe) begin
                voice_d = bus.voice_in;
                vol_d   = bus.voice_vol;
                mvol_d  = bus.master_vol;
                acc_d   = '0;
                idx_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                acc_d = acc_q + ACC_W'(prod);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_VOICES-1)) state_d = MASTER;
            end
            // dout is loaded here so it is visible during OUT alongside dout_valid.
            MASTER: begin
                dout_d  = {~sat[DATA_BITS-1], sat[DATA_BITS-2:0]};
                state_d = OUT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            voice_q <= '0;
            vol_q   <= '0;
            mvol_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            dout_q  <= MID;
        end else begin
            state_q <= state_d;
            voice_q <= voice_d;
            vol_q   <= vol_d;
            mvol_q  <= mvol_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = (state_q == OUT);
    assign bus.busy       = (state_q != IDLE);

`ifdef VOICE_MIXER_CLIP_COUNT_EN
    logic       clip_q;
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (state_q == MASTER) clip_q <= (shifted > SMAX) || (shifted < SMIN);
            if (bus.clip_clear)
                cnt_q <= '0;
            else if (state_q == OUT && clip_q && cnt_q != 8'hFF)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.clip_count = cnt_q;
`endif
endmodule

// File: tb/tb_voice_mixer.sv
// Directed + randomized bench for voice_mixer against an integer reference model.
module tb_voice_mixer;
    localparam int NV = 4, DB = 12, VB = 4;
    localparam int VW = NV*DB, VVW = NV*VB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, errors = 0;
    int   cyc = 0, last_vcyc = 0;

    voice_mixer_if #(.NUM_VOICES(NV), .DATA_BITS(DB), .VOL_BITS(VB)) bus ();
    voice_mixer #(.NUM_VOICES(NV), .DATA_BITS(DB), .VOL_BITS(VB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed mix, floor-divided by 2^(2*VB), clamped, back to offset binary.
    function automatic int model(input logic [VW-1:0] vin, input logic [VVW-1:0] vv,
                                 input logic [VB-1:0] mv);
        int acc, p, q;
        acc = 0;
        for (int i = 0; i < NV; i++)
            acc += (int'(vin[i*DB +: DB]) - 2048) * int'(vv[i*VB +: VB]);
        p = acc * int'(mv);
        q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        if (q > 2047)  q = 2047;
        if (q < -2048) q = -2048;
        return q + 2048;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Strobe once, scramble inputs after the snapshot, then check latency and result.
    task automatic run_mix(input string tag, input logic [VW-1:0] vin,
                           input logic [VVW-1:0] vv, input logic [VB-1:0] mv);
        int exp, lat;
        exp = model(vin, vv, mv);
        bus.voice_in = vin; bus.voice_vol = vv; bus.master_vol = mv;
        bus.sample_strobe = 1'b1;
        step();
        bus.sample_strobe = 1'b0;
        bus.voice_in   = {$urandom, $urandom};
        bus.voice_vol  = VVW'($urandom);
        bus.master_vol = VB'($urandom);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.dout_valid) begin lat = c; break; end
            if (!bus.busy) break;
            step();
        end
        check({tag, "_lat"}, lat, 6);
        check({tag, "_dout"}, int'(bus.dout), exp);
        last_vcyc = cyc;
        step();
        check({tag, "_hold"}, int'(bus.dout), exp);
    endtask

    initial begin
        int pulses, t0;
        bus.sample_strobe = 1'b0;
        bus.voice_in = '0; bus.voice_vol = '0; bus.master_vol = '0;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
        bus.clip_clear = 1'b0;
`endif
        // Held in reset with strobes toggling.
        for (int i = 0; i < 4; i++) begin
            bus.sample_strobe = ~bus.sample_strobe;
            step();
            check("rst_dout", int'(bus.dout), 'h800);
            check("rst_valid", int'(bus.dout_valid), 0);
            check("rst_busy", int'(bus.busy), 0);
        end
        bus.sample_strobe = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Busy window and single voice result.
        bus.voice_in = VW'(12'hFFF); bus.voice_vol = VVW'(4'hF); bus.master_vol = 4'hF;
        bus.sample_strobe = 1'b1;
        step();
        bus.sample_strobe = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check("busy_win", int'(bus.busy), 1);
            check("valid_win", int'(bus.dout_valid), (c == 6) ? 1 : 0);
            if (c < 6) step();
        end
        check("single_dout", int'(bus.dout), 'hF07);
        step();
        check("idle_busy", int'(bus.busy), 0);
        check("idle_valid", int'(bus.dout_valid), 0);

`ifdef VOICE_MIXER_CLIP_COUNT_EN
        bus.clip_clear = 1'b1; step(); bus.clip_clear = 1'b0;
        check("clip_clr0", int'(bus.clip_count), 0);
`endif
        run_mix("sat_hi", {NV{12'hFFF}}, {NV{4'hF}}, 4'hF);
        check("sat_hi_val", int'(bus.dout), 'hFFF);
        run_mix("sat_lo", {NV{12'h000}}, {NV{4'hF}}, 4'hF);
        check("sat_lo_val", int'(bus.dout), 'h000);
`ifdef VOICE_MIXER_CLIP_COUNT_EN
        check("clip_cnt2", int'(bus.clip_count), 2);
        bus.clip_clear = 1'b1; step(); bus.clip_clear = 1'b0;
        check("clip_clr", int'(bus.clip_count), 0);
`endif
        run_mix("neg_floor", VW'(12'h7FF), VVW'(4'hF), 4'hF);
        check("neg_floor_val", int'(bus.dout), 'h7FF);
        run_mix("mute_master", VW'(12'h7FF), VVW'(4'hF), 4'h0);
        check("mute_val", int'(bus.dout), 'h800);
        run_mix("mute_voices", {NV{12'hABC}}, '0, 4'hF);

        // Back-to-back: second strobe in the cycle after OUT.
        t0 = last_vcyc;
        run_mix("b2b", {NV{12'h9A5}}, {NV{4'h3}}, 4'h7);
        check("b2b_gap", last_vcyc - t0, 7);

        // Collision: strobes two cycles in and during OUT are ignored.
        bus.voice_in = {NV{12'hC00}}; bus.voice_vol = {NV{4'h5}}; bus.master_vol = 4'h9;
        bus.sample_strobe = 1'b1; step(); bus.sample_strobe = 1'b0; step();
        bus.sample_strobe = 1'b1; step(); bus.sample_strobe = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            bus.sample_strobe = bus.dout_valid;
            if (bus.dout_valid) pulses++;
            step();
        end
        bus.sample_strobe = 1'b0;
        check("collide_pulses", pulses, 1);
        check("collide_dout", int'(bus.dout), model({NV{12'hC00}}, {NV{4'h5}}, 4'h9));

        // Reset mid-mix aborts without a pulse.
        bus.sample_strobe = 1'b1; step(); bus.sample_strobe = 1'b0;
        step(); step();
        rst_n = 1'b0; #1;
        check("mid_rst_dout", int'(bus.dout), 'h800);
        check("mid_rst_busy", int'(bus.busy), 0);
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.dout_valid) pulses++;
            step();
        end
        check("mid_rst_nopulse", pulses, 0);
        check("mid_rst_hold", int'(bus.dout), 'h800);

        // Randomized mixes.
        for (int n = 0; n < 40; n++)
            run_mix("rand", {$urandom, $urandom}, VVW'($urandom), VB'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
